psf_dmem_arb: RTL and testbench
===============================

// Module: psf_dmem_arb
// PURPOSE
//  Two-port arbiter sharing the 256x32 single-port data RAM (1-cycle read, byte-write, read-first).
//  Port 0 = CPU data side, port 1 = DMA/debug side; one access granted per cycle.
//  Requesters see a valid/accept request channel and a 1-cycle-later ack carrying read data.
//  Sits between the CPU LSU/DMA engine and the RAM instance inside the CPU tile.
// PARAMETERS
//  ADDR_W        8   RAM word-address width (256 words)
//  STARVE_LIMIT  4   consecutive port-1 losses before forced port-1 grant (STARVE_EN only), 1..15
// PORTS
//  clk_i         in   1       single clock, all logic posedge
//  rst_i         in   1       reset, synchronous, active-low
//  m0_rd_i       in   1       port 0 read request
//  m0_wr_i       in   4       port 0 byte write enables (request = rd | |wr)
//  m0_addr_i     in   ADDR_W  port 0 word address
//  m0_data_i     in   32      port 0 write data
//  m0_accept_o   out  1       port 0 request taken this cycle
//  m0_ack_o      out  1       port 0 response, one cycle after accept
//  m0_data_o     out  32      port 0 read data, valid with m0_ack_o
//  m1_*          --   --      identical set for port 1
//  ram_addr_o    out  ADDR_W  to RAM addr
//  ram_data_o    out  32      to RAM write data
//  ram_wr_o      out  4       to RAM byte enables
//  ram_data_i    in   32      from RAM registered read data
// BEHAVIOUR
//  - Request held stable by master until accept; accept is combinational from requests + state.
//  - Grant: port 0 wins if both request; port 1 otherwise. Grant drives ram_* same cycle.
//  - No grant: ram_wr_o=0, ram_addr_o/data_o hold last granted values (no spurious write).
//  - Pipeline reg owner_q{valid,port} set on accept; next cycle mX_ack_o=1 for owner only,
//    mX_data_o=ram_data_i (read-first: rd+wr same request returns pre-write data).
//  - Writes are acked too (data_o = old word). Throughput 1 access/cycle, back-to-back allowed;
//    write then read same addr next cycle returns new data (RAM ordering, no bypass needed).
//  - mX_data_o held at last acked value when ack=0.
//  - Reset (rst_i=0): accepts=0, ram_wr_o=0, acks=0, data_o=0, owner_q cleared, starve_cnt=0;
//    reset asserted with owner_q valid drops that ack (never emitted after reset).
//  - Request with rd=0, wr=0 is not a request; never accepted.
// CONFIGURATION
//  DMEM_ARB_STARVE_EN defined: 4-bit starve_cnt++ each cycle port 1 requests and loses;
//    cleared when port 1 accepted or not requesting; at starve_cnt==STARVE_LIMIT port 1
//    wins over port 0 for that cycle, then count clears. Saturates, never wraps.
//  Undefined: strict port-0 priority, port 1 may starve indefinitely; no counter logic.
// STRUCTURE
//  psf_dmem_defs.vh: port index constants (PORT_CPU=0, PORT_DMA=1), default ADDR_W,
//    default STARVE_LIMIT.
//  Sub-module psf_dmem_arb_grant: request vector + starve state -> one-hot grant.
//  Top instantiates grant, request mux, owner_q pipeline, response demux; RAM outside.
// TESTING
//  1 m0 write addr 0x10 data 0xDEADBEEF wr=4'hF, then m0 read 0x10 -> ack next cycle, data 0xDEADBEEF.
//  2 m0 and m1 both request every cycle -> m0 accepted each cycle; m1 accepted only when m0 idle
//    (no STARVE_EN); with STARVE_EN, LIMIT=4, m1 accepted every 5th cycle.
//  3 m1 wr=4'b0010 data 0x0000AB00 to word holding 0x11223344 -> later read 0x1122AB44.
//  4 m0 rd+wr same request, word=0x1, write 0x2 -> ack data 0x1; next read -> 0x2.
//  5 rst_i low on cycle after accept -> no ack either port, ram_wr_o=0 throughout reset.
//  6 Idle cycles between requests -> ram_wr_o stays 0, no ack pulses, data_o unchanged.

Source files
------------

// File: rtl/psf_dmem_arb_pkg.sv
// Shared constants and types for the data-RAM arbiter (port indices, defaults, owner record).
package psf_dmem_arb_pkg;

  localparam int PORT_CPU         = 0;
  localparam int PORT_DMA         = 1;
  localparam int DEF_ADDR_W       = 8;
  localparam int DEF_STARVE_LIMIT = 4;

  typedef struct packed {
    logic valid;
    logic port;
  } owner_t;

  function automatic logic is_req(input logic rd, input logic [3:0] wr);
    return rd | (|wr);
  endfunction

endpackage

// File: rtl/psf_dmem_arb_grant.sv
// One-hot grant for the two RAM requesters: CPU priority unless the DMA side is being forced.
module psf_dmem_arb_grant
  import psf_dmem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       starve_force_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = '0;
    if (req_i[PORT_DMA] && starve_force_i) begin
      gnt_o[PORT_DMA] = 1'b1;
    end else if (req_i[PORT_CPU]) begin
      gnt_o[PORT_CPU] = 1'b1;
    end else if (req_i[PORT_DMA]) begin
      gnt_o[PORT_DMA] = 1'b1;
    end
  end

endmodule

// File: rtl/psf_dmem_arb.sv
// Two-port arbiter in front of the single-port 256x32 data RAM; acks carry read-first data.
// Define DMEM_ARB_STARVE_EN to add the port-1 anti-starvation counter.
module psf_dmem_arb
  import psf_dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_rd_i,
  input  logic [3:0]        m0_wr_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [31:0]       m0_data_i,
  output logic              m0_accept_o,
  output logic              m0_ack_o,
  output logic [31:0]       m0_data_o,
  input  logic              m1_rd_i,
  input  logic [3:0]        m1_wr_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [31:0]       m1_data_i,
  output logic              m1_accept_o,
  output logic              m1_ack_o,
  output logic [31:0]       m1_data_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [31:0]       ram_data_o,
  output logic [3:0]        ram_wr_o,
  input  logic [31:0]       ram_data_i
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("psf_dmem_arb: STARVE_LIMIT must be 1..15");
  end

  logic [1:0]        req;
  logic [1:0]        gnt_raw;
  logic [1:0]        gnt;
  logic              starve_force;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  owner_t            owner_q, owner_d;
  logic [31:0]       m0_rdata_q, m1_rdata_q;
  logic              ack0, ack1;

  assign req[PORT_CPU] = is_req(m0_rd_i, m0_wr_i);
  assign req[PORT_DMA] = is_req(m1_rd_i, m1_wr_i);

  psf_dmem_arb_grant u_grant (
    .req_i          (req),
    .starve_force_i (starve_force),
    .gnt_o          (gnt_raw)
  );

  // Reset is synchronous, so the combinational grant must be masked while it is held.
  assign gnt         = gnt_raw & {2{rst_i}};
  assign m0_accept_o = gnt[PORT_CPU];
  assign m1_accept_o = gnt[PORT_DMA];

`ifdef DMEM_ARB_STARVE_EN
  logic [3:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!req[PORT_DMA] || gnt[PORT_DMA]) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != 4'hF) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) starve_cnt_q <= '0;
    else        starve_cnt_q <= starve_cnt_d;
  end

  assign starve_force = (starve_cnt_q == 4'(STARVE_LIMIT));
`else
  assign starve_force = 1'b0;
`endif

  // Address and write data hold their last granted values so the RAM pins stay quiet when idle.
  always_comb begin
    ram_addr_o = addr_q;
    ram_data_o = wdata_q;
    ram_wr_o   = '0;
    if (gnt[PORT_DMA]) begin
      ram_addr_o = m1_addr_i;
      ram_data_o = m1_data_i;
      ram_wr_o   = m1_wr_i;
    end else if (gnt[PORT_CPU]) begin
      ram_addr_o = m0_addr_i;
      ram_data_o = m0_data_i;
      ram_wr_o   = m0_wr_i;
    end
  end

  always_comb begin
    owner_d.valid = |gnt;
    owner_d.port  = gnt[PORT_DMA];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      addr_q  <= '0;
      wdata_q <= '0;
      owner_q <= '0;
    end else begin
      addr_q  <= ram_addr_o;
      wdata_q <= ram_data_o;
      owner_q <= owner_d;
    end
  end

  // An access in flight when reset arrives is dropped, not acked.
  assign ack0 = rst_i & owner_q.valid & ~owner_q.port;
  assign ack1 = rst_i & owner_q.valid &  owner_q.port;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      if (ack0) m0_rdata_q <= ram_data_i;
      if (ack1) m1_rdata_q <= ram_data_i;
    end
  end

  assign m0_ack_o  = ack0;
  assign m1_ack_o  = ack1;
  assign m0_data_o = !rst_i ? 32'h0 : (ack0 ? ram_data_i : m0_rdata_q);
  assign m1_data_o = !rst_i ? 32'h0 : (ack1 ? ram_data_i : m1_rdata_q);

endmodule

// File: tb/tb_psf_dmem_arb.sv
// Directed bench for psf_dmem_arb with a behavioural read-first byte-write RAM model.
// Expectations for the contention test follow DMEM_ARB_STARVE_EN (LIMIT=4 when defined).
module tb_psf_dmem_arb;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        m0_rd_i, m1_rd_i;
  logic [3:0]  m0_wr_i, m1_wr_i;
  logic [7:0]  m0_addr_i, m1_addr_i;
  logic [31:0] m0_data_i, m1_data_i;
  logic        m0_accept_o, m0_ack_o, m1_accept_o, m1_ack_o;
  logic [31:0] m0_data_o, m1_data_o;
  logic [7:0]  ram_addr_o;
  logic [31:0] ram_data_o, ram_data_i;
  logic [3:0]  ram_wr_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [256];

  always #5 clk_i = ~clk_i;

  psf_dmem_arb dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .m0_rd_i     (m0_rd_i),
    .m0_wr_i     (m0_wr_i),
    .m0_addr_i   (m0_addr_i),
    .m0_data_i   (m0_data_i),
    .m0_accept_o (m0_accept_o),
    .m0_ack_o    (m0_ack_o),
    .m0_data_o   (m0_data_o),
    .m1_rd_i     (m1_rd_i),
    .m1_wr_i     (m1_wr_i),
    .m1_addr_i   (m1_addr_i),
    .m1_data_i   (m1_data_i),
    .m1_accept_o (m1_accept_o),
    .m1_ack_o    (m1_ack_o),
    .m1_data_o   (m1_data_o),
    .ram_addr_o  (ram_addr_o),
    .ram_data_o  (ram_data_o),
    .ram_wr_o    (ram_wr_o),
    .ram_data_i  (ram_data_i)
  );

  // RAM: registered read of the old word, byte-lane write on the same edge.
  always @(posedge clk_i) begin
    ram_data_i <= mem[ram_addr_o];
    for (int b = 0; b < 4; b++)
      if (ram_wr_o[b]) mem[ram_addr_o][8*b +: 8] <= ram_data_o[8*b +: 8];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic set_m0(input logic rd, input logic [3:0] wr, input logic [7:0] a, input logic [31:0] d);
    m0_rd_i = rd; m0_wr_i = wr; m0_addr_i = a; m0_data_i = d;
  endtask

  task automatic set_m1(input logic rd, input logic [3:0] wr, input logic [7:0] a, input logic [31:0] d);
    m1_rd_i = rd; m1_wr_i = wr; m1_addr_i = a; m1_data_i = d;
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic exp_acc0, exp_acc1, prev_acc0, prev_acc1;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    rst_i = 1'b0;
    set_m0(1'b0, 4'hF, 8'h10, 32'hDEADBEEF);
    set_m1(1'b1, 4'h0, 8'h20, 32'h0);

    // Reset with both ports requesting: nothing may be accepted or written.
    #1;
    for (int c = 0; c < 3; c++) begin
      chk("rst_acc0", {31'd0, m0_accept_o}, 32'd0);
      chk("rst_acc1", {31'd0, m1_accept_o}, 32'd0);
      chk("rst_ramwr", {28'd0, ram_wr_o}, 32'd0);
      tick();
      chk("rst_ack", {30'd0, m0_ack_o, m1_ack_o}, 32'd0);
      chk("rst_d0", m0_data_o, 32'h0);
    end

    // Test 1: write then back-to-back read of 0x10.
    set_m1(1'b0, 4'h0, 8'h00, 32'h0);
    rst_i = 1'b1;
    #1;
    chk("t1_acc0", {31'd0, m0_accept_o}, 32'd1);
    chk("t1_ramwr", {28'd0, ram_wr_o}, 32'hF);
    chk("t1_ramaddr", {24'd0, ram_addr_o}, 32'h10);
    chk("t1_ramdata", ram_data_o, 32'hDEADBEEF);
    tick();
    chk("t1_wack", {31'd0, m0_ack_o}, 32'd1);
    chk("t1_wold", m0_data_o, 32'h0);
    set_m0(1'b1, 4'h0, 8'h10, 32'h0);
    #1;
    chk("t1_racc", {31'd0, m0_accept_o}, 32'd1);
    tick();
    chk("t1_rack", {31'd0, m0_ack_o}, 32'd1);
    chk("t1_rdata", m0_data_o, 32'hDEADBEEF);
    set_m0(1'b0, 4'h0, 8'h55, 32'h12345678);

    // Test 6: idle cycles.
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("idle_acc", {30'd0, m0_accept_o, m1_accept_o}, 32'd0);
      chk("idle_ramwr", {28'd0, ram_wr_o}, 32'd0);
      chk("idle_addr", {24'd0, ram_addr_o}, 32'h10);
      tick();
      chk("idle_ack", {30'd0, m0_ack_o, m1_ack_o}, 32'd0);
      chk("idle_d0", m0_data_o, 32'hDEADBEEF);
    end

    // Test 3: m1 byte-lane write over 0x11223344.
    set_m0(1'b0, 4'hF, 8'h20, 32'h11223344);
    tick();
    set_m0(1'b0, 4'h0, 8'h00, 32'h0);
    set_m1(1'b0, 4'b0010, 8'h20, 32'h0000AB00);
    #1;
    chk("t3_acc1", {31'd0, m1_accept_o}, 32'd1);
    chk("t3_ramwr", {28'd0, ram_wr_o}, 32'h2);
    tick();
    chk("t3_wack", {31'd0, m1_ack_o}, 32'd1);
    chk("t3_ack0", {31'd0, m0_ack_o}, 32'd0);
    chk("t3_wold", m1_data_o, 32'h11223344);
    set_m1(1'b1, 4'h0, 8'h20, 32'h0);
    tick();
    chk("t3_rack", {31'd0, m1_ack_o}, 32'd1);
    chk("t3_rdata", m1_data_o, 32'h1122AB44);
    set_m1(1'b0, 4'h0, 8'h00, 32'h0);
    tick();
    chk("t3_hold", m1_data_o, 32'h1122AB44);

    // Test 4: rd+wr in one request is read-first.
    set_m0(1'b0, 4'hF, 8'h30, 32'h1);
    tick();
    set_m0(1'b1, 4'hF, 8'h30, 32'h2);
    tick();
    chk("t4_ack", {31'd0, m0_ack_o}, 32'd1);
    chk("t4_old", m0_data_o, 32'h1);
    set_m0(1'b1, 4'h0, 8'h30, 32'h0);
    tick();
    chk("t4_new", m0_data_o, 32'h2);
    set_m0(1'b0, 4'h0, 8'h00, 32'h0);
    tick();

    // Test 2: both ports request every cycle.
    set_m0(1'b1, 4'h0, 8'h10, 32'h0);
    set_m1(1'b1, 4'h0, 8'h20, 32'h0);
    #1;
    for (int k = 0; k < 10; k++) begin
`ifdef DMEM_ARB_STARVE_EN
      exp_acc1 = ((k % 5) == 4);
`else
      exp_acc1 = 1'b0;
`endif
      exp_acc0 = ~exp_acc1;
      chk($sformatf("t2_acc0_%0d", k), {31'd0, m0_accept_o}, {31'd0, exp_acc0});
      chk($sformatf("t2_acc1_%0d", k), {31'd0, m1_accept_o}, {31'd0, exp_acc1});
      prev_acc0 = exp_acc0;
      prev_acc1 = exp_acc1;
      tick();
      chk($sformatf("t2_ack0_%0d", k), {31'd0, m0_ack_o}, {31'd0, prev_acc0});
      chk($sformatf("t2_ack1_%0d", k), {31'd0, m1_ack_o}, {31'd0, prev_acc1});
      if (prev_acc0) chk("t2_d0", m0_data_o, 32'hDEADBEEF);
      if (prev_acc1) chk("t2_d1", m1_data_o, 32'h1122AB44);
    end
    set_m0(1'b0, 4'h0, 8'h00, 32'h0);
    #1;
    chk("t2_m1_alone", {31'd0, m1_accept_o}, 32'd1);
    tick();
    chk("t2_m1_ack", {31'd0, m1_ack_o}, 32'd1);
    chk("t2_m1_data", m1_data_o, 32'h1122AB44);
    set_m1(1'b0, 4'h0, 8'h00, 32'h0);
    tick();

    // Test 5: reset on the cycle after an accept drops the ack.
    set_m0(1'b1, 4'h0, 8'h10, 32'h0);
    #1;
    chk("t5_acc", {31'd0, m0_accept_o}, 32'd1);
    tick();
    rst_i = 1'b0;
    set_m0(1'b0, 4'hF, 8'h10, 32'hFFFFFFFF);
    #1;
    chk("t5_ack_rst", {30'd0, m0_ack_o, m1_ack_o}, 32'd0);
    chk("t5_ramwr", {28'd0, ram_wr_o}, 32'd0);
    chk("t5_d0", m0_data_o, 32'h0);
    tick();
    chk("t5_ramwr2", {28'd0, ram_wr_o}, 32'd0);
    chk("t5_ack2", {30'd0, m0_ack_o, m1_ack_o}, 32'd0);
    set_m0(1'b0, 4'h0, 8'h00, 32'h0);
    rst_i = 1'b1;
    tick();
    chk("t5_noack", {30'd0, m0_ack_o, m1_ack_o}, 32'd0);
    chk("t5_d0_clr", m0_data_o, 32'h0);
    set_m0(1'b1, 4'h0, 8'h10, 32'h0);
    tick();
    chk("t5_mem_ok", m0_data_o, 32'hDEADBEEF);
    set_m0(1'b0, 4'h0, 8'h00, 32'h0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
